// File: rtl/sram_pkg.sv
// Shared configuration, lane geometry and parity helper for the interface RAM.
package sram_pkg;

    localparam int unsigned AW    = 15;
    localparam int unsigned DW    = 32;
    localparam int unsigned PW    = 4;
    localparam int unsigned KW    = 32;
    localparam int unsigned BW0   = 9;
    localparam int unsigned LANES = 4;
    localparam int unsigned WCNT  = 32768;
    localparam int unsigned SW    = BW0 * LANES;

    typedef struct packed {
        int unsigned AW;
        int unsigned DW;
        int unsigned KW;
        int unsigned PW;
        int unsigned WCNT;
        int unsigned AWX;
        logic        isBWEN;
        logic        isSCMB;
        logic        isPRT;
        int unsigned EVITVL;
    } sramcfg_t;

    // Byte-write on, scrambling off, parity on.
    localparam sramcfg_t IFRAM_CFG = '{AW, DW, KW, PW, WCNT, 0, 1'b1, 1'b0, 1'b1, 0};

    typedef enum logic [1:0] {
        AccIdle,
        AccRead,
        AccWrite
    } acc_e;

    function automatic logic lane_parity(input logic [7:0] data, input logic even);
        return even ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/ifram_ctl_macro_if.sv
// RAM slave port bundle between the interface subsystem and the interface RAM.
interface ifram_ctl_macro_if;
    import sram_pkg::*;

    logic          ramen;
    logic          ramcs;
    logic [AW-1:0] ramaddr;
    logic [PW-1:0] ramwr;
    logic [DW-1:0] ramwdata;
    logic [DW-1:0] ramrdata;
    logic          ramready;

    modport master (
        output ramen, ramcs, ramaddr, ramwr, ramwdata,
        input  ramrdata, ramready
    );

    modport slave (
        input  ramen, ramcs, ramaddr, ramwr, ramwdata,
        output ramrdata, ramready
    );

endinterface

// File: rtl/clk_gate_cell.sv
// Latch-based glitch-free clock gate; scan enable forces the gate open.
module clk_gate_cell (
    input  logic clk,
    input  logic en,
    input  logic se,
    output logic gclk
);

    logic en_l;

    // Transparent while clk is low so the enable is stable across the high phase.
    always_latch begin
        if (!clk) begin
            en_l <= en | se;
        end
    end

    assign gclk = clk & en_l;

endmodule

// File: rtl/ifram_ctl_macro.sv
// 32K x 32 interface RAM: byte-parity storage array, registered read port and gated array clock.
module ifram_ctl_macro
    import sram_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmsatpg,
    input  logic              cmsbist,
    input  logic [KW-1:0]     scmbkey,
    input  logic              even,
    ifram_ctl_macro_if.slave  ramif,
    output logic              prerr,
    output logic              verifyerr
);

    acc_e          access;
    logic          array_clk;
    logic [SW-1:0] mem [WCNT];

    logic [SW-1:0] rword_q;
    logic          rd_q;
    logic          even_q;
    logic          verr_q;
    logic          par_bad;
    logic [DW-1:0] rdata;

    logic unused_in;
    assign unused_in = ^{cmsbist, scmbkey};

    // Accesses presented while reset is held are dropped.
    always_comb begin
        access = AccIdle;
        if (ramif.ramen && ramif.ramcs && !resetn) begin
            access = (|ramif.ramwr) ? AccWrite : AccRead;
        end
    end

    clk_gate_cell u_clk_gate (
        .clk  (clk),
        .en   (access != AccIdle),
        .se   (cmsatpg),
        .gclk (array_clk)
    );

    always_ff @(posedge array_clk) begin
        if (access == AccWrite) begin
            for (int j = 0; j < LANES; j++) begin
                if (ramif.ramwr[j]) begin
                    mem[ramif.ramaddr][j*BW0 +: BW0] <=
                        {lane_parity(ramif.ramwdata[j*8 +: 8], even), ramif.ramwdata[j*8 +: 8]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            rword_q <= '0;
            rd_q    <= 1'b0;
            even_q  <= 1'b0;
            verr_q  <= 1'b0;
        end else begin
            rd_q <= (access == AccRead);
            if (access == AccRead) begin
                rword_q <= mem[ramif.ramaddr];
                even_q  <= even;
            end
            if (prerr) begin
                verr_q <= 1'b1;
            end
        end
    end

    always_comb begin
        par_bad = 1'b0;
        rdata   = '0;
        for (int j = 0; j < LANES; j++) begin
            rdata[j*8 +: 8] = rword_q[j*BW0 +: 8];
            if (rword_q[j*BW0 + 8] != lane_parity(rword_q[j*BW0 +: 8], even_q)) begin
                par_bad = 1'b1;
            end
        end
    end

    // Error only flags the cycle right after a read edge; held data is not re-checked.
    assign prerr          = rd_q & par_bad & IFRAM_CFG.isPRT;
    assign verifyerr      = verr_q | prerr;
    assign ramif.ramrdata = rdata;
    assign ramif.ramready = 1'b1;

endmodule

// File: tb/tb_ifram_ctl_macro.sv
// Directed, table-driven bench for the interface RAM controller.
module tb_ifram_ctl_macro;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmsatpg;
    logic        cmsbist;
    logic [31:0] scmbkey;
    logic        even;
    logic        prerr;
    logic        verifyerr;

    int checks   = 0;
    int failures = 0;
    int gcnt     = 0;

    ifram_ctl_macro_if bus ();

    ifram_ctl_macro dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmsatpg   (cmsatpg),
        .cmsbist   (cmsbist),
        .scmbkey   (scmbkey),
        .even      (even),
        .ramif     (bus),
        .prerr     (prerr),
        .verifyerr (verifyerr)
    );

    always #5 clk = ~clk;

    always @(posedge dut.array_clk) gcnt++;

    typedef struct {
        logic        en;
        logic        cs;
        logic [14:0] addr;
        logic [3:0]  wr;
        logic [31:0] wdata;
        logic        ev;
        logic [31:0] exp_rdata;
        logic        exp_prerr;
        logic        exp_verr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic cs, logic [14:0] addr, logic [3:0] wr,
                                logic [31:0] wdata, logic ev, logic [31:0] er, logic ep,
                                logic ev_err);
        vec_t v;
        v.en = en; v.cs = cs; v.addr = addr; v.wr = wr; v.wdata = wdata; v.ev = ev;
        v.exp_rdata = er; v.exp_prerr = ep; v.exp_verr = ev_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic cs, input logic [14:0] addr,
                         input logic [3:0] wr, input logic [31:0] wdata, input logic ev);
        bus.ramen    = en;
        bus.ramcs    = cs;
        bus.ramaddr  = addr;
        bus.ramwr    = wr;
        bus.ramwdata = wdata;
        even         = ev;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn  = 1'b1;
        cmsatpg = 1'b0;
        cmsbist = 1'b0;
        scmbkey = 32'h5A5A_1234;
        drive(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1);
        step();
        step();
        check("reset_rdata", bus.ramrdata, 32'h0);
        check("reset_prerr", {31'b0, prerr}, 32'h0);
        check("reset_verr", {31'b0, verifyerr}, 32'h0);
        check("reset_ready", {31'b0, bus.ramready}, 32'h1);
        resetn = 1'b0;
        step();

        //         en   cs   addr     wr    wdata          ev   exp_rdata      pe   ve
        vecs.push_back(mk(1, 1, 15'h0000, 4'hF, 32'h12345678, 1, 32'h00000000, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0000, 4'h0, 32'h0,        1, 32'h12345678, 0, 0));
        vecs.push_back(mk(1, 1, 15'h7FFF, 4'hF, 32'hFFFFFFFF, 1, 32'h12345678, 0, 0));
        vecs.push_back(mk(1, 1, 15'h7FFF, 4'h1, 32'h000000AA, 1, 32'h12345678, 0, 0));
        vecs.push_back(mk(1, 1, 15'h7FFF, 4'h0, 32'h0,        1, 32'hFFFFFFAA, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0010, 4'hF, 32'hCAFEF00D, 1, 32'hFFFFFFAA, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0001, 4'hF, 32'h11111111, 1, 32'hFFFFFFAA, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0002, 4'hF, 32'h22222222, 1, 32'hFFFFFFAA, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0003, 4'hF, 32'h33333333, 1, 32'hFFFFFFAA, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0001, 4'h0, 32'h0,        1, 32'h11111111, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0002, 4'h0, 32'h0,        1, 32'h22222222, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0003, 4'h0, 32'h0,        1, 32'h33333333, 0, 0));
        vecs.push_back(mk(0, 0, 15'h0000, 4'h0, 32'h0,        1, 32'h33333333, 0, 0));
        // Odd-parity write, partial odd-parity overwrite, then odd-parity read: no error.
        vecs.push_back(mk(1, 1, 15'h0200, 4'hF, 32'hA5A5A5A5, 0, 32'h33333333, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0200, 4'h4, 32'h00000000, 0, 32'h33333333, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0200, 4'h0, 32'h0,        0, 32'hA500A5A5, 0, 0));
        // Written with even parity, read back with odd sense.
        vecs.push_back(mk(1, 1, 15'h0100, 4'hF, 32'h00000001, 1, 32'hA500A5A5, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0100, 4'h0, 32'h0,        0, 32'h00000001, 1, 1));
        vecs.push_back(mk(0, 0, 15'h0000, 4'h0, 32'h0,        1, 32'h00000001, 0, 1));
        vecs.push_back(mk(0, 1, 15'h0100, 4'h0, 32'h0,        1, 32'h00000001, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].cs, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].ev);
            step();
            check($sformatf("vec%0d_rdata", i), bus.ramrdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_prerr", i), {31'b0, prerr}, {31'b0, vecs[i].exp_prerr});
            check($sformatf("vec%0d_verr", i), {31'b0, verifyerr}, {31'b0, vecs[i].exp_verr});
            check($sformatf("vec%0d_ready", i), {31'b0, bus.ramready}, 32'h1);
        end

        // Write blocked by ramen=0: no array clock, contents and rdata untouched.
        drive(1'b0, 1'b1, 15'h0010, 4'hF, 32'h00000000, 1'b1);
        gcnt = 0;
        step();
        check("blocked_gclk", gcnt, 0);
        check("blocked_rdata", bus.ramrdata, 32'h00000001);
        drive(1'b1, 1'b1, 15'h0010, 4'h0, 32'h0, 1'b1);
        gcnt = 0;
        step();
        check("access_gclk", gcnt, 1);
        check("blocked_readback", bus.ramrdata, 32'hCAFEF00D);
        check("blocked_prerr", {31'b0, prerr}, 32'h0);

        // Scan mode opens the gate even when idle.
        drive(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1);
        cmsatpg = 1'b1;
        gcnt = 0;
        step();
        check("scan_gclk", gcnt, 1);
        check("scan_rdata", bus.ramrdata, 32'hCAFEF00D);
        cmsatpg = 1'b0;
        step();

        // Fresh parity error, then asynchronous reset mid-sequence.
        drive(1'b1, 1'b1, 15'h0100, 4'h0, 32'h0, 1'b0);
        step();
        check("pre_rst_prerr", {31'b0, prerr}, 32'h1);
        drive(1'b1, 1'b1, 15'h0001, 4'hF, 32'hDEADBEEF, 1'b1);
        resetn = 1'b1;
        #1;
        check("async_rst_rdata", bus.ramrdata, 32'h0);
        check("async_rst_prerr", {31'b0, prerr}, 32'h0);
        check("async_rst_verr", {31'b0, verifyerr}, 32'h0);
        step();
        step();
        drive(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1);
        resetn = 1'b0;
        step();
        check("post_rst_verr", {31'b0, verifyerr}, 32'h0);
        drive(1'b1, 1'b1, 15'h0000, 4'h0, 32'h0, 1'b1);
        step();
        check("post_rst_rd0", bus.ramrdata, 32'h12345678);
        drive(1'b1, 1'b1, 15'h0001, 4'h0, 32'h0, 1'b1);
        step();
        check("post_rst_rd1", bus.ramrdata, 32'h11111111);
        check("post_rst_prerr", {31'b0, prerr}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifram_ctl_macro.md
Name: ifram_ctl_macro

Overview:
- Single-port 32K x 32-bit interface RAM: SRAM controller, 32K x 36 storage array and macro clock gate in one block.
- Each 8-bit byte is stored with one parity bit, as 9-bit lanes (4 lanes, 36 bits/word).
- Sits behind the interface-subsystem RAM slave port (ramif slave).
- Scrambling is disabled in this instance; parity generation and checking are always on.

Parameters:
AW  15  word address width (32768 words)
DW  32  data width seen by the master
PW  4  parity bits per word, one per byte
BW0  9  stored lane width (8 data + 1 parity)
KW  32  scramble key width (port kept, function disabled)

Ports:
clk  in  1  single clock; all state on rising edge
resetn  in  1  asynchronous, active-high reset (asserted when 1)
cmsatpg  in  1  scan mode; forces macro clock gate open
cmsbist  in  1  BIST mode flag; no functional effect in this block
scmbkey  in  KW  scramble key; ignored (scrambling disabled)
even  in  1  parity sense: 1 = even parity, 0 = odd parity
ramen  in  1  RAM enable; access qualifier
ramcs  in  1  chip select; access valid this cycle
ramaddr  in  AW  word address
ramwr  in  4  per-byte write strobes; any bit set makes the access a write
ramwdata  in  DW  write data
ramrdata  out  DW  read data
ramready  out  1  constant 1; no wait states
prerr  out  1  one-cycle parity error pulse
verifyerr  out  1  sticky parity error flag

Behaviour:
- Access qualifier: acc = ramen & ramcs.
  - Write when acc & |ramwr.
  - Read when acc & ~|ramwr.
  - No access otherwise.
- Storage layout: lane j occupies bits [9j+8:9j] = {par_j, data[8j+7:8j]}.
- Parity generation: par_j = ^data_byte_j when even=1; par_j = ~^data_byte_j when even=0.
- Write:
  - Completes in the cycle it is presented.
  - Only lanes with ramwr[j]=1 are updated (data and parity); other lanes are untouched.
  - ramrdata holds its previous value.
- Read latency is 1:
  - Address sampled at edge N; ramrdata valid after edge N and held until the next read.
  - Idle cycles and writes do not change ramrdata.
- Parity check:
  - Applied to all 4 lanes of every read, using the `even` value registered at the read edge.
  - prerr = 1 for exactly the cycle ramrdata presents a word with any lane mismatch; 0 otherwise.
  - Data is still returned unmodified.
- verifyerr sets on any prerr and stays set until reset.
- ramready = 1 always. Back-to-back accesses every cycle are supported.
- Clock gating:
  - Array clock enable = acc | cmsatpg.
  - Latch-based, glitch-free gate: enable latched while clk is low, output = clk & latched enable.
  - No array clock pulses while idle.
- Reset (async assert, sync-safe release):
  - ramrdata=0, prerr=0, verifyerr=0.
  - Array contents are not reset; reads of never-written words return undefined data and undefined parity status.
  - Access presented during reset assertion is ignored.
- Out-of-range address cannot occur: AW bits cover exactly 32768 words.
- scmbkey, cmsbist: no effect on data path.

Decomposition:
- Shared package sram_pkg holds:
  - sramcfg_t (AW, DW, KW, PW, WCNT, AWX, isBWEN, isSCMB, isPRT, EVITVL);
  - lane constants BW0=9, lane count=4.
- Sub-module clk_gate_cell: latch-based clock gate with enable and scan-enable inputs.
- Array and parity logic stay in the top block.

Test Plan:
- even=1; write addr 0x0000 = 0x12345678, ramwr=4'hF; read 0x0000 -> ramrdata=0x12345678 one cycle later, prerr=0.
- Partial write:
  - write 0x7FFF = 0xFFFFFFFF (all lanes);
  - write 0x7FFF = 0x000000AA with ramwr=4'h1;
  - read 0x7FFF -> 0xFFFFFFAA, prerr=0.
- Parity error:
  - write 0x0100 = 0x00000001 with even=1;
  - read 0x0100 with even=0 -> ramrdata=0x00000001, prerr=1 for one cycle, verifyerr=1 and stays 1 through idle cycles.
- ramen=0 with ramcs=1 and ramwr=4'hF to 0x0010 -> no write; a subsequent read of 0x0010 returns the prior contents; array clock does not toggle in the ramen=0 cycle.
- Back-to-back reads 0x0001, 0x0002, 0x0003 every cycle -> data returned on consecutive cycles in order; ramready=1 throughout.
- Assert resetn=1 mid-sequence after a parity error -> ramrdata=0, prerr=0, verifyerr=0 immediately; data written before reset is readable after release.
